otter_cu: RTL and testbench

- Multicycle control unit for the RV32I OTTER core: instruction decoder plus sequencing FSM.
- It is the producer side of the 4-bit ALU function code the datapath ALU consumes.
- It also drives ALU operand selects, PC/regfile/memory enables and writeback selects.
- It sequences fetch, execute, load-writeback and interrupt entry.

---
 rtl/otter_pkg.sv | 81 ++++++++
 rtl/otter_cu_dcdr.sv | 134 +++++++++++++
 rtl/otter_cu.sv | 118 +++++++++++
 tb/tb_otter_cu.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// otter_pkg: shared encodings for the OTTER multicycle control unit.
// Holds opcode, ALU function and FSM state enums plus the mux-select constants
// that the control unit drives into the datapath.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b1000,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SLL   = 4'b0001,
    ALU_SRA   = 4'b1101,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_COPYB = 4'b1001
  } alu_fun_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_INTR  = 2'd3
  } state_t;

  // ALU operand A select
  localparam logic [1:0] SRCA_RS1   = 2'd0;
  localparam logic [1:0] SRCA_UIMM  = 2'd1;
  localparam logic [1:0] SRCA_NRS1  = 2'd2;

  // ALU operand B select
  localparam logic [2:0] SRCB_RS2   = 3'd0;
  localparam logic [2:0] SRCB_IIMM  = 3'd1;
  localparam logic [2:0] SRCB_SIMM  = 3'd2;
  localparam logic [2:0] SRCB_PC    = 3'd3;
  localparam logic [2:0] SRCB_CSR   = 3'd4;
  localparam logic [2:0] SRCB_ZERO  = 3'd5;

  // next-PC select
  localparam logic [2:0] PC_SEL_PC4    = 3'd0;
  localparam logic [2:0] PC_SEL_JALR   = 3'd1;
  localparam logic [2:0] PC_SEL_BRANCH = 3'd2;
  localparam logic [2:0] PC_SEL_JAL    = 3'd3;
  localparam logic [2:0] PC_SEL_MTVEC  = 3'd4;
  localparam logic [2:0] PC_SEL_MEPC   = 3'd5;

  // register-file writeback select
  localparam logic [1:0] RF_WR_PC4  = 2'd0;
  localparam logic [1:0] RF_WR_CSR  = 2'd1;
  localparam logic [1:0] RF_WR_DMEM = 2'd2;
  localparam logic [1:0] RF_WR_ALU  = 2'd3;

  // branch condition from funct3 and comparator flags; undefined funct3 is not taken
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
    case (f3)
      3'b000:  return eq;
      3'b001:  return ~eq;
      3'b100:  return lt;
      3'b101:  return ~lt;
      3'b110:  return ltu;
      3'b111:  return ~ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/otter_cu_dcdr.sv
// otter_cu_dcdr: combinational RV32I instruction decoder for the OTTER control unit.
// Ports: ir/branch flags in; ALU function, operand/PC/writeback selects and
// execute-phase strobes out. With exec=0 every output is zero (fetch values).
module otter_cu_dcdr
  import otter_pkg::*;
(
  input  logic [31:0] ir,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  input  logic        exec,
  output logic [3:0]  alu_fun,
  output logic [1:0]  srca_sel,
  output logic [2:0]  srcb_sel,
  output logic [2:0]  pc_sel,
  output logic [1:0]  rf_wr_sel,
  output logic        pc_we,
  output logic        reg_we,
  output logic        mem_we2,
  output logic        mem_rden2,
  output logic        csr_we,
  output logic        mret_exec
);

  logic [2:0] f3;
  opcode_t    opc;

  assign f3  = ir[14:12];
  assign opc = opcode_t'(ir[6:0]);

  always_comb begin
    alu_fun   = ALU_ADD;
    srca_sel  = SRCA_RS1;
    srcb_sel  = SRCB_RS2;
    pc_sel    = PC_SEL_PC4;
    rf_wr_sel = RF_WR_PC4;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    mem_we2   = 1'b0;
    mem_rden2 = 1'b0;
    csr_we    = 1'b0;
    mret_exec = 1'b0;

    if (exec) begin
      // every instruction except a load advances the PC in execute;
      // loads advance it in the writeback state instead
      pc_we = 1'b1;
      case (opc)
        OPC_OP: begin
          alu_fun   = {ir[30], f3};
          reg_we    = 1'b1;
          rf_wr_sel = RF_WR_ALU;
        end
        OPC_OPIMM: begin
          // ir[30] only selects SRA among immediates; for ADDI it is immediate data
          alu_fun   = {ir[30] & (f3 == 3'b101), f3};
          srcb_sel  = SRCB_IIMM;
          reg_we    = 1'b1;
          rf_wr_sel = RF_WR_ALU;
        end
        OPC_LUI: begin
          alu_fun   = ALU_COPYB;
          srca_sel  = SRCA_UIMM;
          reg_we    = 1'b1;
          rf_wr_sel = RF_WR_ALU;
        end
        OPC_AUIPC: begin
          alu_fun   = ALU_ADD;
          srca_sel  = SRCA_UIMM;
          srcb_sel  = SRCB_PC;
          reg_we    = 1'b1;
          rf_wr_sel = RF_WR_ALU;
        end
        OPC_JAL: begin
          pc_sel    = PC_SEL_JAL;
          reg_we    = 1'b1;
          rf_wr_sel = RF_WR_PC4;
        end
        OPC_JALR: begin
          pc_sel    = PC_SEL_JALR;
          reg_we    = 1'b1;
          rf_wr_sel = RF_WR_PC4;
        end
        OPC_BRANCH: begin
          pc_sel = branch_taken(f3, br_eq, br_lt, br_ltu) ? PC_SEL_BRANCH : PC_SEL_PC4;
        end
        OPC_LOAD: begin
          alu_fun   = ALU_ADD;
          srcb_sel  = SRCB_IIMM;
          mem_rden2 = 1'b1;
          pc_we     = 1'b0;
        end
        OPC_STORE: begin
          alu_fun  = ALU_ADD;
          srcb_sel = SRCB_SIMM;
          mem_we2  = 1'b1;
        end
        OPC_SYSTEM: begin
          case (f3)
            3'b001: begin // CSRRW: rs1 + 0 passes rs1 to the CSR
              alu_fun   = ALU_ADD;
              srcb_sel  = SRCB_ZERO;
              csr_we    = 1'b1;
              reg_we    = 1'b1;
              rf_wr_sel = RF_WR_CSR;
            end
            3'b010: begin // CSRRS: csr | rs1
              alu_fun   = ALU_OR;
              srcb_sel  = SRCB_CSR;
              csr_we    = 1'b1;
              reg_we    = 1'b1;
              rf_wr_sel = RF_WR_CSR;
            end
            3'b011: begin // CSRRC: csr & ~rs1
              alu_fun   = ALU_AND;
              srca_sel  = SRCA_NRS1;
              srcb_sel  = SRCB_CSR;
              csr_we    = 1'b1;
              reg_we    = 1'b1;
              rf_wr_sel = RF_WR_CSR;
            end
            3'b000: begin
              pc_sel    = PC_SEL_MEPC;
              mret_exec = 1'b1;
            end
            default: ; // unsupported SYSTEM forms retire as NOP
          endcase
        end
        default: ; // illegal opcode: NOP, PC+4 only
      endcase
    end
  end

endmodule

// File: rtl/otter_cu.sv
// otter_cu: multicycle control unit (decoder + fetch/exec/writeback/interrupt FSM).
// Ports: CLK, RST (sync, active-high); IR and branch flags in; INTR pending interrupt;
// ALU_FUN, operand/PC/writeback selects and write/read strobes out, all combinational.
module otter_cu
  import otter_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IR,
  input  logic        BR_EQ,
  input  logic        BR_LT,
  input  logic        BR_LTU,
  input  logic        INTR,
  output logic [3:0]  ALU_FUN,
  output logic [1:0]  SRCA_SEL,
  output logic [2:0]  SRCB_SEL,
  output logic [2:0]  PC_SEL,
  output logic [1:0]  RF_WR_SEL,
  output logic        PC_WE,
  output logic        REG_WE,
  output logic        MEM_WE2,
  output logic        MEM_RDEN1,
  output logic        MEM_RDEN2,
  output logic        CSR_WE,
  output logic        INT_TAKEN,
  output logic        MRET_EXEC
);

  state_t state, next_state;

  logic [3:0] d_alu_fun;
  logic [1:0] d_srca_sel;
  logic [2:0] d_srcb_sel;
  logic [2:0] d_pc_sel;
  logic [1:0] d_rf_wr_sel;
  logic       d_pc_we, d_reg_we, d_mem_we2, d_mem_rden2, d_csr_we, d_mret_exec;
  logic       pc_we_s, reg_we_s, mem_we2_s, csr_we_s, int_taken_s, mret_exec_s;
  logic       is_load;

  assign is_load = (IR[6:0] == OPC_LOAD);

  otter_cu_dcdr u_dcdr (
    .ir        (IR),
    .br_eq     (BR_EQ),
    .br_lt     (BR_LT),
    .br_ltu    (BR_LTU),
    .exec      (state == ST_EXEC),
    .alu_fun   (d_alu_fun),
    .srca_sel  (d_srca_sel),
    .srcb_sel  (d_srcb_sel),
    .pc_sel    (d_pc_sel),
    .rf_wr_sel (d_rf_wr_sel),
    .pc_we     (d_pc_we),
    .reg_we    (d_reg_we),
    .mem_we2   (d_mem_we2),
    .mem_rden2 (d_mem_rden2),
    .csr_we    (d_csr_we),
    .mret_exec (d_mret_exec)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = ST_FETCH;
    ALU_FUN     = d_alu_fun;
    SRCA_SEL    = d_srca_sel;
    SRCB_SEL    = d_srcb_sel;
    PC_SEL      = d_pc_sel;
    RF_WR_SEL   = d_rf_wr_sel;
    pc_we_s     = d_pc_we;
    reg_we_s    = d_reg_we;
    mem_we2_s   = d_mem_we2;
    csr_we_s    = d_csr_we;
    mret_exec_s = d_mret_exec;
    int_taken_s = 1'b0;
    MEM_RDEN1   = 1'b0;
    MEM_RDEN2   = d_mem_rden2;

    case (state)
      ST_FETCH: begin
        MEM_RDEN1  = 1'b1;
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        // loads defer their writes to ST_WB, so interrupt entry waits until after it
        if (is_load)   next_state = ST_WB;
        else if (INTR) next_state = ST_INTR;
        else           next_state = ST_FETCH;
      end
      ST_WB: begin
        reg_we_s   = 1'b1;
        pc_we_s    = 1'b1;
        RF_WR_SEL  = RF_WR_DMEM;
        PC_SEL     = PC_SEL_PC4;
        next_state = INTR ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
        PC_SEL      = PC_SEL_MTVEC;
        pc_we_s     = 1'b1;
        int_taken_s = 1'b1;
        next_state  = ST_FETCH;
      end
      default: next_state = ST_FETCH;
    endcase
  end

  // an instruction interrupted by reset must not commit any architectural write
  assign PC_WE     = pc_we_s     & ~RST;
  assign REG_WE    = reg_we_s    & ~RST;
  assign MEM_WE2   = mem_we2_s   & ~RST;
  assign CSR_WE    = csr_we_s    & ~RST;
  assign INT_TAKEN = int_taken_s & ~RST;
  assign MRET_EXEC = mret_exec_s & ~RST;

endmodule

// File: tb/tb_otter_cu.sv
module tb_otter_cu;

  logic        CLK = 1'b0;
  logic        RST, BR_EQ, BR_LT, BR_LTU, INTR;
  logic [31:0] IR;
  logic [3:0]  ALU_FUN;
  logic [1:0]  SRCA_SEL, RF_WR_SEL;
  logic [2:0]  SRCB_SEL, PC_SEL;
  logic        PC_WE, REG_WE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE, INT_TAKEN, MRET_EXEC;

  int passed = 0;
  int total  = 0;

  otter_cu dut (
    .CLK(CLK), .RST(RST), .IR(IR), .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
    .INTR(INTR), .ALU_FUN(ALU_FUN), .SRCA_SEL(SRCA_SEL), .SRCB_SEL(SRCB_SEL),
    .PC_SEL(PC_SEL), .RF_WR_SEL(RF_WR_SEL), .PC_WE(PC_WE), .REG_WE(REG_WE),
    .MEM_WE2(MEM_WE2), .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2), .CSR_WE(CSR_WE),
    .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // from ST_FETCH: present an instruction and advance into ST_EXEC
  task automatic issue(input logic [31:0] instr);
    IR = instr;
    step();
    #1;
  endtask

  initial begin
    RST = 1'b1; IR = 32'h0000_0013; BR_EQ = 1'b0; BR_LT = 1'b0; BR_LTU = 1'b0; INTR = 1'b0;
    step();
    chk("rst_hold_pc_we", PC_WE, 0);
    chk("rst_hold_reg_we", REG_WE, 0);
    step();
    RST = 1'b0;
    #1;
    // ST_FETCH after reset
    chk("fetch_rden1", MEM_RDEN1, 1);
    chk("fetch_pc_we", PC_WE, 0);
    chk("fetch_reg_we", REG_WE, 0);
    chk("fetch_mem_we2", MEM_WE2, 0);
    chk("fetch_csr_we", CSR_WE, 0);
    chk("fetch_alu", ALU_FUN, 4'b0000);
    chk("fetch_pc_sel", PC_SEL, 0);

    // SUB
    issue(32'h402081B3);
    chk("sub_rden1", MEM_RDEN1, 0);
    chk("sub_alu", ALU_FUN, 4'b1000);
    chk("sub_reg_we", REG_WE, 1);
    chk("sub_rf_sel", RF_WR_SEL, 3);
    chk("sub_pc_we", PC_WE, 1);
    step();
    chk("sub_back_fetch", MEM_RDEN1, 1);

    // ADD
    issue(32'h002081B3);
    chk("add_alu", ALU_FUN, 4'b0000);
    step();

    // ADDI -1024: ir[30]=1 must not turn it into sub
    issue(32'hC0008193);
    chk("addi_neg_alu", ALU_FUN, 4'b0000);
    chk("addi_srcb", SRCB_SEL, 1);
    step();

    // SRAI
    issue(32'h4040D193);
    chk("srai_alu", ALU_FUN, 4'b1101);
    chk("srai_srcb", SRCB_SEL, 1);
    step();

    // LW: exec, writeback, fetch = 3 cycles
    issue(32'h0080A283);
    chk("lw_exec_rden2", MEM_RDEN2, 1);
    chk("lw_exec_pc_we", PC_WE, 0);
    chk("lw_exec_reg_we", REG_WE, 0);
    chk("lw_exec_srcb", SRCB_SEL, 1);
    step();
    chk("lw_wb_reg_we", REG_WE, 1);
    chk("lw_wb_rf_sel", RF_WR_SEL, 2);
    chk("lw_wb_pc_we", PC_WE, 1);
    chk("lw_wb_pc_sel", PC_SEL, 0);
    chk("lw_wb_rden1", MEM_RDEN1, 0);
    step();
    chk("lw_back_fetch", MEM_RDEN1, 1);

    // BEQ taken / not taken
    issue(32'h00208463);
    BR_EQ = 1'b1; #1;
    chk("beq_taken_pc_sel", PC_SEL, 2);
    chk("beq_taken_reg_we", REG_WE, 0);
    BR_EQ = 1'b0; #1;
    chk("beq_nt_pc_sel", PC_SEL, 0);
    chk("beq_nt_reg_we", REG_WE, 0);
    step();

    // BNE with BR_EQ=0 is taken
    issue(32'h00209463);
    chk("bne_taken_pc_sel", PC_SEL, 2);
    step();

    // undefined branch funct3 never taken
    issue(32'h0020A463);
    BR_EQ = 1'b1; BR_LT = 1'b1; BR_LTU = 1'b1; #1;
    chk("bundef_pc_sel", PC_SEL, 0);
    BR_EQ = 1'b0; BR_LT = 1'b0; BR_LTU = 1'b0;
    step();

    // SW
    issue(32'h0020A023);
    chk("sw_mem_we2", MEM_WE2, 1);
    chk("sw_srcb", SRCB_SEL, 2);
    chk("sw_reg_we", REG_WE, 0);
    step();

    // CSRRC
    issue(32'h3000B1F3);
    chk("csrrc_alu", ALU_FUN, 4'b0111);
    chk("csrrc_srca", SRCA_SEL, 2);
    chk("csrrc_srcb", SRCB_SEL, 4);
    chk("csrrc_csr_we", CSR_WE, 1);
    chk("csrrc_rf_sel", RF_WR_SEL, 1);
    step();

    // illegal opcode: NOP
    issue(32'hFFFFFFFF);
    chk("ill_pc_we", PC_WE, 1);
    chk("ill_reg_we", REG_WE, 0);
    chk("ill_mem_we2", MEM_WE2, 0);
    chk("ill_pc_sel", PC_SEL, 0);
    step();

    // LUI with an interrupt pending in exec
    issue(32'h123450B7);
    INTR = 1'b1; #1;
    chk("lui_alu", ALU_FUN, 4'b1001);
    chk("lui_srca", SRCA_SEL, 1);
    chk("lui_reg_we", REG_WE, 1);
    step();
    INTR = 1'b0; #1;
    chk("intr_pc_sel", PC_SEL, 4);
    chk("intr_taken", INT_TAKEN, 1);
    chk("intr_pc_we", PC_WE, 1);
    chk("intr_reg_we", REG_WE, 0);
    step();
    chk("intr_back_fetch", MEM_RDEN1, 1);
    chk("fetch_no_int_taken", INT_TAKEN, 0);

    // MRET
    issue(32'h30200073);
    chk("mret_pc_sel", PC_SEL, 5);
    chk("mret_exec", MRET_EXEC, 1);
    step();

    // reset during ST_WB discards the load
    issue(32'h0080A283);
    step();
    RST = 1'b1; #1;
    chk("rst_wb_reg_we", REG_WE, 0);
    chk("rst_wb_pc_we", PC_WE, 0);
    step();
    RST = 1'b0; #1;
    chk("rst_wb_to_fetch", MEM_RDEN1, 1);
    chk("rst_wb_fetch_reg_we", REG_WE, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
